aes_round_scheduler: RTL and testbench

//  Controller that time-shares one combinational AES round datapath (fwd/inv round,
//  ARK-only first round, no-MixColumns last round) between an encrypt and a decrypt

---
 rtl/aes_round_scheduler.sv | 138 +++++++++++++
 tb/tb_aes_round_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_scheduler.sv
// Round-robin scheduler that time-shares one combinational AES round datapath between
// an encrypt and a decrypt requester; one round per clock, result on a valid/ready port.
module aes_round_scheduler #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic         clks,
    input  logic         reset,
    input  logic         enc_valid,
    output logic         enc_ready,
    input  logic [127:0] enc_data,
    input  logic         dec_valid,
    output logic         dec_ready,
    input  logic [127:0] dec_data,
    output logic [127:0] eng_data_in,
    output logic         eng_mode,
    output logic         eng_first,
    output logic         eng_last,
    output logic [3:0]   eng_key_idx,
    input  logic [127:0] eng_data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode,
    output logic         busy
);

    localparam logic [3:0] NR_C = 4'(Nr);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_data;
    logic [3:0]   r_round;
    logic         r_mode;
    logic         r_last_grant;
    logic         w_grant_enc;
    logic         w_grant_dec;
    logic         w_accept;
    logic         w_run;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = w_grant_enc | w_grant_dec;

    // Round-robin grant in IDLE; readies stay low while reset is asserted
    always_comb begin
        w_grant_enc = 1'b0;
        w_grant_dec = 1'b0;
        if ((r_state == ST_IDLE) && reset) begin
            if (enc_valid && dec_valid) begin
                w_grant_enc = r_last_grant;
                w_grant_dec = ~r_last_grant;
            end else begin
                w_grant_enc = enc_valid;
                w_grant_dec = dec_valid;
            end
        end else begin
            w_grant_enc = 1'b0;
            w_grant_dec = 1'b0;
        end
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RUN;
                else          w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (r_round == NR_C) w_state_nxt = ST_DONE;
                else                 w_state_nxt = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clks or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Block state, round counter, mode and arbitration history
    always_ff @(posedge clks or negedge reset) begin
        if (!reset) begin
            r_data       <= 128'd0;
            r_round      <= 4'd0;
            r_mode       <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data       <= w_grant_dec ? dec_data : enc_data;
                        r_mode       <= w_grant_dec;
                        r_last_grant <= w_grant_dec;
                        r_round      <= 4'd0;
                    end
                end
                ST_RUN: begin
                    r_data <= eng_data_out;
                    // counter parks at Nr on the final round so it can never wrap
                    if (r_round != NR_C) r_round <= r_round + 4'd1;
                end
                ST_DONE: begin
                    if (out_ready) r_round <= 4'd0;
                end
                default: begin
                    r_round <= 4'd0;
                end
            endcase
        end
    end

    assign enc_ready   = w_grant_enc;
    assign dec_ready   = w_grant_dec;
    assign eng_data_in = r_data;
    assign eng_mode    = r_mode;
    assign eng_first   = w_run & (r_round == 4'd0);
    assign eng_last    = w_run & (r_round == NR_C);
    assign eng_key_idx = w_run ? (r_mode ? (NR_C - r_round) : r_round) : 4'd0;
    assign out_valid   = (r_state == ST_DONE);
    assign out_data    = r_data;
    assign out_mode    = r_mode;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: two instances (Nk=4, Nk=8), each driven by a behavioural
// AES round datapath, checked against a full-cipher reference and FIPS-197 vectors.
module tb_aes_round_scheduler;

    logic         clks = 1'b0;
    logic         reset;
    logic         enc_valid [2];
    logic         enc_ready [2];
    logic [127:0] enc_data  [2];
    logic         dec_valid [2];
    logic         dec_ready [2];
    logic [127:0] dec_data  [2];
    logic [127:0] eng_in    [2];
    logic         eng_mode  [2];
    logic         eng_first [2];
    logic         eng_last  [2];
    logic [3:0]   eng_idx   [2];
    logic [127:0] eng_out   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_data  [2];
    logic         out_mode  [2];
    logic         busy      [2];

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [2][15];
    bit           last_g [2];
    int           n_checks;
    int           n_fail;

    always #5 clks = ~clks;

    aes_round_scheduler #(.Nk(4)) u_dut4 (
        .clks(clks), .reset(reset),
        .enc_valid(enc_valid[0]), .enc_ready(enc_ready[0]), .enc_data(enc_data[0]),
        .dec_valid(dec_valid[0]), .dec_ready(dec_ready[0]), .dec_data(dec_data[0]),
        .eng_data_in(eng_in[0]), .eng_mode(eng_mode[0]), .eng_first(eng_first[0]),
        .eng_last(eng_last[0]), .eng_key_idx(eng_idx[0]), .eng_data_out(eng_out[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_mode(out_mode[0]), .busy(busy[0])
    );

    aes_round_scheduler #(.Nk(8)) u_dut8 (
        .clks(clks), .reset(reset),
        .enc_valid(enc_valid[1]), .enc_ready(enc_ready[1]), .enc_data(enc_data[1]),
        .dec_valid(dec_valid[1]), .dec_ready(dec_ready[1]), .dec_data(dec_data[1]),
        .eng_data_in(eng_in[1]), .eng_mode(eng_mode[1]), .eng_first(eng_first[1]),
        .eng_last(eng_last[1]), .eng_key_idx(eng_idx[1]), .eng_data_out(eng_out[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_mode(out_mode[1]), .busy(busy[1])
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] getb(input logic [127:0] x, input int i);
        return x[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 16; i++)
            y[127-8*i -: 8] = inv ? isbox[getb(x, i)] : sbox[getb(x, i)];
        return y;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        int src;
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (r + 4 * ((c - r + 4) % 4)) : (r + 4 * ((c + r) % 4));
                y[127-8*(r+4*c) -: 8] = getb(x, src);
            end
        return y;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j - r + 4) % 4], getb(x, j + 4 * c));
                y[127-8*(r+4*c) -: 8] = acc;
            end
        return y;
    endfunction

    // One round as the external datapath performs it, selected by the eng_* controls
    function automatic logic [127:0] eng_model(input logic [127:0] d, input logic m,
                                               input logic f, input logic l, input logic [127:0] key);
        logic [127:0] t;
        if (f) begin
            t = d ^ key;
        end else if (!m) begin
            t = shift_rows(sub_bytes(d, 1'b0), 1'b0);
            if (!l) t = mix(t, 1'b0);
            t = t ^ key;
        end else begin
            t = sub_bytes(shift_rows(d, 1'b1), 1'b1) ^ key;
            if (!l) t = mix(t, 1'b1);
        end
        return t;
    endfunction

    // Whole-block FIPS-197 Cipher / InvCipher
    function automatic logic [127:0] aes_ref(input logic [127:0] d, input bit m, input int k);
        int nr;
        logic [127:0] s;
        nr = (k == 0) ? 10 : 14;
        if (!m) begin
            s = d ^ rk[k][0];
            for (int r = 1; r <= nr; r++) begin
                s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
                if (r != nr) s = mix(s, 1'b0);
                s = s ^ rk[k][r];
            end
        end else begin
            s = d ^ rk[k][nr];
            for (int r = nr - 1; r >= 0; r--) begin
                s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[k][r];
                if (r != 0) s = mix(s, 1'b1);
            end
        end
        return s;
    endfunction

    always_comb eng_out[0] = eng_model(eng_in[0], eng_mode[0], eng_first[0], eng_last[0], rk[0][eng_idx[0]]);
    always_comb eng_out[1] = eng_model(eng_in[1], eng_mode[1], eng_first[1], eng_last[1], rk[1][eng_idx[1]]);

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int u = 1; u < 256; u++)
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[v]  = b;
            isbox[b] = 8'(v);
        end
    endtask

    task automatic expand(input int k, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nk + 6; r++) rk[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at negedge+1 with valids already set; returns at negedge+1 of the IDLE cycle
    task automatic serve(input int k, input int nstall, output logic [127:0] got);
        int nr;
        int lat;
        int nsteps;
        logic ch;
        logic [127:0] din;
        logic [127:0] exp;
        logic [127:0] hold_d;
        bit rdy_bad;
        bit seq_bad;
        bit stab_bad;
        nr  = (k == 0) ? 10 : 14;
        ch  = (enc_valid[k] && dec_valid[k]) ? ~last_g[k] : dec_valid[k];
        din = ch ? dec_data[k] : enc_data[k];
        exp = aes_ref(din, ch, k);
        #1;
        chk("grant", 128'({enc_ready[k], dec_ready[k]}), ch ? 128'd1 : 128'd2);
        @(posedge clks);
        last_g[k] = ch;
        @(negedge clks);
        if (ch) dec_valid[k] = 1'b0; else enc_valid[k] = 1'b0;
        lat = 0; nsteps = 0; rdy_bad = 1'b0; seq_bad = 1'b0; stab_bad = 1'b0;
        #1;
        while (!out_valid[k] && lat < 40) begin
            if (enc_ready[k] || dec_ready[k] || !busy[k]) rdy_bad = 1'b1;
            if (eng_idx[k] != (ch ? 4'(nr - nsteps) : 4'(nsteps)) || eng_first[k] != (nsteps == 0) ||
                eng_last[k] != (nsteps == nr) || eng_mode[k] != ch) seq_bad = 1'b1;
            nsteps++;
            @(negedge clks); #1;
            lat++;
        end
        chk("latency", 128'(lat), 128'(nr + 1));
        chk("run_ctrl", 128'({seq_bad, rdy_bad}), 128'd0);
        chk("out_data", out_data[k], exp);
        chk("out_mode", 128'(out_mode[k]), 128'(ch));
        got    = out_data[k];
        hold_d = out_data[k];
        for (int i = 0; i < nstall; i++) begin
            @(negedge clks); #1;
            if (!out_valid[k] || out_data[k] !== hold_d || out_mode[k] !== ch ||
                enc_ready[k] || dec_ready[k]) stab_bad = 1'b1;
        end
        chk("stall_hold", 128'(stab_bad), 128'd0);
        out_ready[k] = 1'b1;
        @(posedge clks);
        @(negedge clks);
        out_ready[k] = 1'b0;
        #1;
        chk("release", 128'({out_valid[k], busy[k]}), 128'd0);
    endtask

    typedef struct {
        int           k;
        bit           m;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [4];
        logic [127:0] got;

        n_checks = 0;
        n_fail   = 0;
        build_sbox();
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        vt[0] = '{0, 1'b0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{0, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vt[2] = '{1, 1'b0, 128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
        vt[3] = '{1, 1'b1, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};

        for (int k = 0; k < 2; k++) begin
            enc_valid[k] = 1'b0; dec_valid[k] = 1'b0; out_ready[k] = 1'b0;
            enc_data[k] = '0; dec_data[k] = '0; last_g[k] = 1'b1;
        end
        reset = 1'b0;
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ctrl", 128'({busy[k], out_valid[k], enc_ready[k], dec_ready[k], out_mode[k],
                                  eng_mode[k], eng_first[k], eng_last[k], eng_idx[k]}), 128'd0);
            chk("rst_data", out_data[k] | eng_in[k], 128'd0);
        end

        // Both requesters valid from reset: grants alternate enc, dec, enc
        enc_data[0]  = {$urandom, $urandom, $urandom, $urandom};
        dec_data[0]  = {$urandom, $urandom, $urandom, $urandom};
        enc_valid[0] = 1'b1; dec_valid[0] = 1'b1;
        #1;
        chk("rst_ready", 128'({enc_ready[0], dec_ready[0]}), 128'd0);
        @(negedge clks);
        reset = 1'b1;
        serve(0, 0, got);
        enc_data[0] = {$urandom, $urandom, $urandom, $urandom}; enc_valid[0] = 1'b1;
        serve(0, 0, got);
        dec_data[0] = {$urandom, $urandom, $urandom, $urandom}; dec_valid[0] = 1'b1;
        serve(0, 0, got);

        // Result held 5 cycles with encrypt pending; encrypt taken right after the handshake
        enc_data[0] = {$urandom, $urandom, $urandom, $urandom}; enc_valid[0] = 1'b1;
        serve(0, 5, got);
        serve(0, 0, got);

        for (int i = 0; i < 4; i++) begin
            if (vt[i].m) begin dec_data[vt[i].k] = vt[i].din; dec_valid[vt[i].k] = 1'b1; end
            else         begin enc_data[vt[i].k] = vt[i].din; enc_valid[vt[i].k] = 1'b1; end
            serve(vt[i].k, i, got);
            chk("fips_vec", got, vt[i].exp);
        end

        // Asynchronous reset in round 5 of an encrypt, then a fresh request
        enc_data[0] = {$urandom, $urandom, $urandom, $urandom}; enc_valid[0] = 1'b1;
        @(posedge clks);
        @(negedge clks);
        enc_valid[0] = 1'b0;
        repeat (5) @(negedge clks);
        #1;
        chk("mid_round", 128'(eng_idx[0]), 128'd5);
        #1;
        reset = 1'b0;
        dec_valid[0] = 1'b1;
        #1;
        chk("async_rst", 128'({busy[0], out_valid[0], enc_ready[0], dec_ready[0], eng_idx[0]}), 128'd0);
        @(negedge clks);
        reset = 1'b1;
        dec_valid[0] = 1'b0;
        last_g[0] = 1'b1; last_g[1] = 1'b1;
        enc_data[0] = {$urandom, $urandom, $urandom, $urandom}; enc_valid[0] = 1'b1;
        serve(0, 0, got);

        // Random traffic on both channels with random result back-pressure
        for (int k = 0; k < 2; k++) begin
            for (int it = 0; it < 12; it++) begin
                if (!enc_valid[k] && ($urandom % 2 == 0)) begin
                    enc_data[k] = {$urandom, $urandom, $urandom, $urandom}; enc_valid[k] = 1'b1;
                end
                if (!dec_valid[k] && ($urandom % 2 == 0)) begin
                    dec_data[k] = {$urandom, $urandom, $urandom, $urandom}; dec_valid[k] = 1'b1;
                end
                if (!enc_valid[k] && !dec_valid[k]) begin
                    enc_data[k] = {$urandom, $urandom, $urandom, $urandom}; enc_valid[k] = 1'b1;
                end
                serve(k, int'($urandom_range(0, 3)), got);
            end
            enc_valid[k] = 1'b0;
            dec_valid[k] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
